// File: rtl/sbox_layer_engine.sv
// sbox_layer_engine: multi-cycle forward/inverse 4-bit S-box layer with valid/ready handshake
module sbox_layer_engine #(
  parameter int BLOCKSIZE = 64,
  parameter int LANES     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BLOCKSIZE-1:0] in_data,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BLOCKSIZE-1:0] out_data,
  output logic                 busy
);
  localparam int NIB   = BLOCKSIZE / 4;
  localparam int STEPS = NIB / LANES;
  localparam int CW    = STEPS > 1 ? $clog2(STEPS) : 1;
  localparam logic [63:0] FWD = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV = 64'hA970364BD21C8FE5;

  if (BLOCKSIZE % 4 != 0 || NIB % LANES != 0) begin : g_bad
    $error("sbox_layer_engine: BLOCKSIZE must be a multiple of 4 and BLOCKSIZE/4 divisible by LANES");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_nxt;
  logic [BLOCKSIZE-1:0] blk, blk_sub;
  logic                 mode;
  logic [CW-1:0]        cnt;
  logic                 last;

  assign last = cnt == CW'(STEPS - 1);

  for (genvar i = 0; i < NIB; i++) begin : g_nib
    logic [3:0] x;
    assign x = blk[4*i +: 4];
    assign blk_sub[4*i +: 4] = cnt == CW'(i / LANES) ? (mode ? INV[{x, 2'b00} +: 4] : FWD[{x, 2'b00} +: 4]) : x;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: accept in IDLE, step through groups in BUSY, hold in DONE until retired
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = in_valid ? BUSY : IDLE;
      BUSY:    state_nxt = last ? DONE : BUSY;
      DONE:    state_nxt = out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // block, mode and step counter: capture on acceptance, substitute one group per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk  <= '0;
      mode <= 1'b0;
      cnt  <= '0;
    end else if (state == IDLE && in_valid) begin
      blk  <= in_data;
      mode <= in_mode;
      cnt  <= '0;
    end else if (state == BUSY) begin
      blk <= blk_sub;
      cnt <= last ? cnt : cnt + 1'b1;
    end
  end

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign out_data  = blk;
endmodule
